// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared encodings and helpers for the MEM/WB stage
package mem_wb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mw_state_t;

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - data-memory request/response port of the MEM/WB stage
interface mem_wb_if #(
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_hit;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata, mem_hit
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata, mem_hit
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, lane-replicated store data and misalign detect
module mem_lane_align
    import mem_wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = lane_cnt(DATA_W),
    localparam int OFF_W  = off_w(DATA_W)
) (
    input  logic [1:0]        size_i,
    input  logic [2:0]        addr_lo_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misalign_o
);

    int off;

    always_comb begin
        off        = 32'(addr_lo_i[OFF_W-1:0]);
        be_o       = '0;
        wdata_o    = '0;
        misalign_o = 1'b0;
        // Enables cover the naturally aligned group that contains the offset.
        for (int i = 0; i < BE_W; i++) begin
            case (size_i)
                SZ_B: begin
                    be_o[i]          = (i == off);
                    wdata_o[i*8 +: 8] = store_data_i[7:0];
                end
                SZ_H: begin
                    be_o[i]          = ((i / 2) == (off / 2));
                    wdata_o[i*8 +: 8] = store_data_i[(i % 2)*8 +: 8];
                end
                SZ_W: begin
                    be_o[i]          = ((i / 4) == (off / 4));
                    wdata_o[i*8 +: 8] = store_data_i[(i % 4)*8 +: 8];
                end
                default: begin
                    be_o[i]          = 1'b1;
                    wdata_o[i*8 +: 8] = store_data_i[i*8 +: 8];
                end
            endcase
        end
        case (size_i)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = addr_lo_i[0];
            SZ_W:    misalign_o = |addr_lo_i[1:0];
            default: misalign_o = (DATA_W == 32) ? 1'b1 : |addr_lo_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MW pipeline register with variable-latency data-memory port
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int CNT_W      = 32,
    localparam int BE_W       = lane_cnt(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     alu_out_e,
    input  logic [DATA_W-1:0]     store_data_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [DATA_W-1:0]     pc_e,
    input  logic                  mem_read_e,
    input  logic                  mem_write_e,
    input  logic [1:0]            mem_size_e,
    input  logic                  reg_write_e,
    input  logic                  load_npc_e,
    output logic [DATA_W-1:0]     alu_out_mw,
    output logic [REG_ADDR_W-1:0] rd_mw,
    output logic [DATA_W-1:0]     pc_mw,
    output logic                  reg_write_mw,
    output logic                  mem_to_reg_mw,
    output logic                  load_npc_mw,
    output logic                  misalign_mw,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_stall,
    mem_wb_if.master              mem,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    localparam int OFF_W = off_w(DATA_W);

    mw_state_t         state_q;
    logic              misalign;
    logic              acc;
    logic              resp;
    logic [BE_W-1:0]   req_be_d,    req_be_q;
    logic [DATA_W-1:0] req_wdata_d, req_wdata_q;
    logic [DATA_W-1:0] req_addr_d,  req_addr_q;
    logic              req_we_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [CNT_W-1:0]  hit_q, miss_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i       (mem_size_e),
        .addr_lo_i    (alu_out_e[2:0]),
        .store_data_i (store_data_e),
        .be_o         (req_be_d),
        .wdata_o      (req_wdata_d),
        .misalign_o   (misalign)
    );

    assign req_addr_d = {alu_out_e[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    assign acc        = (mem_read_e | mem_write_e) & ~misalign & ~clear;
    assign resp       = (state_q == WAIT) & mem.mem_rvalid;
    assign mem_stall  = ((state_q == IDLE) & acc) | (state_q == REQ) | (state_q == WAIT);

    // IDLE presents the request straight from E; later states replay the captured payload.
    always_comb begin
        if (state_q == IDLE) begin
            mem.mem_req   = acc;
            mem.mem_we    = mem_write_e;
            mem.mem_addr  = req_addr_d;
            mem.mem_wdata = req_wdata_d;
            mem.mem_be    = req_be_d;
        end else begin
            mem.mem_req   = (state_q == REQ);
            mem.mem_we    = req_we_q;
            mem.mem_addr  = req_addr_q;
            mem.mem_wdata = req_wdata_q;
            mem.mem_be    = req_be_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_we_q    <= 1'b0;
            rbuf_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    req_addr_q  <= req_addr_d;
                    req_wdata_q <= req_wdata_d;
                    req_be_q    <= req_be_d;
                    req_we_q    <= mem_write_e;
                    state_q     <= mem.mem_ready ? WAIT : REQ;
                end
                REQ:  if (mem.mem_ready) state_q <= WAIT;
                WAIT: if (mem.mem_rvalid) begin
                    rbuf_q  <= mem.mem_rdata;
                    state_q <= DONE;
                end
                DONE: if (en) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_mw    <= '0;
            rd_mw         <= '0;
            pc_mw         <= '0;
            reg_write_mw  <= 1'b0;
            mem_to_reg_mw <= 1'b0;
            load_npc_mw   <= 1'b0;
            misalign_mw   <= 1'b0;
            rd_data_q     <= '0;
        end else if (en) begin
            if (clear) begin
                alu_out_mw    <= '0;
                rd_mw         <= '0;
                pc_mw         <= '0;
                reg_write_mw  <= 1'b0;
                mem_to_reg_mw <= 1'b0;
                load_npc_mw   <= 1'b0;
                misalign_mw   <= 1'b0;
            end else begin
                alu_out_mw    <= alu_out_e;
                rd_mw         <= rd_e;
                pc_mw         <= pc_e;
                reg_write_mw  <= reg_write_e;
                mem_to_reg_mw <= mem_read_e;
                load_npc_mw   <= load_npc_e;
                misalign_mw   <= misalign & (mem_read_e | mem_write_e);
            end
            rd_data_q <= (~clear & (state_q == DONE) & ~req_we_q) ? rbuf_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (cnt_clr) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (resp) begin
            if (mem.mem_hit && !(&hit_q))
                hit_q <= hit_q + CNT_W'(1);
            if (!mem.mem_hit && !(&miss_q))
                miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign rd_data  = rd_data_q;
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised successor to the single-cycle EX/MEM-to-WB segment register.
- Registers EX results into the MW stage and drives a variable-latency data-memory port with a req/ready then rvalid handshake, replacing the fixed cache-miss wire.
- Generates byte enables and aligned store data, flags misaligned accesses, holds load data across stalls, and keeps saturating hit/miss counters.

Parameters:
- DATA_W, 32, datapath and memory word width; only 32 or 64 are legal.
- REG_ADDR_W, 5, register-file index width.
- CNT_W, 32, width of each performance counter.
- BE_W, DATA_W/8, byte-lane count (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  pipeline advance from the hazard unit
- clear  in  1  flush; MW contents become a bubble on advance
- alu_out_e  in  DATA_W  effective address / ALU result
- store_data_e  in  DATA_W  forwarded store data
- rd_e  in  REG_ADDR_W  destination register
- pc_e  in  DATA_W  PC
- mem_read_e  in  1  load
- mem_write_e  in  1  store
- mem_size_e  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
- reg_write_e  in  1  write-back enable
- load_npc_e  in  1  write-back selects PC+4
- alu_out_mw  out  DATA_W  registered copy of alu_out_e
- rd_mw  out  REG_ADDR_W  registered copy of rd_e
- pc_mw  out  DATA_W  registered copy of pc_e
- reg_write_mw  out  1  registered copy of reg_write_e
- mem_to_reg_mw  out  1  registered copy of mem_read_e
- load_npc_mw  out  1  registered copy of load_npc_e
- misalign_mw  out  1  registered misaligned-access flag
- rd_data  out  DATA_W  load word for the load-extension block
- mem_stall  out  1  stall request to the hazard unit
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  DATA_W  word-aligned address
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  BE_W  byte enables
- mem_ready  in  1  request accepted
- mem_rvalid  in  1  response/ack, for reads and writes
- mem_rdata  in  DATA_W  read data
- mem_hit  in  1  qualifies mem_rvalid as a hit
- cnt_clr  in  1  synchronous counter clear
- hit_cnt  out  CNT_W  hit count
- miss_cnt  out  CNT_W  miss count

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs and counters go to 0, the response buffer goes to 0, FSM goes to IDLE.
- Access rule:
  - acc = (mem_read_e|mem_write_e) & ~misalign & ~clear.
  - misalign = half with addr[0]=1, word with addr[1:0]≠0, dword with addr[2:0]≠0, or size 11 when DATA_W=32.
- Lanes:
  - mem_addr is alu_out_e with the low log2(BE_W) bits zeroed.
  - Byte store: mem_be = one-hot at the byte offset; mem_wdata = byte replicated.
  - Half store: two adjacent lanes; mem_wdata = halfword replicated.
  - Word store: four lanes.
  - Dword store: all lanes.
- FSM, states IDLE, REQ, WAIT, DONE:
  - IDLE: on acc, mem_req=1 combinationally; go to WAIT if mem_ready, else REQ.
  - REQ: hold mem_req and the payload stable; go to WAIT on mem_ready; clear is ignored here.
  - WAIT: on mem_rvalid, capture mem_rdata into the response buffer, increment hit_cnt if mem_hit else miss_cnt, then go to DONE.
  - DONE: go to IDLE when en=1, otherwise stay.
- mem_stall = (state==IDLE & acc) | state==REQ | state==WAIT. It is low in DONE.
- Minimum access costs 2 stall cycles: accept, then response.
- MW register on posedge when en=1:
  - clear=1: all fields 0.
  - Otherwise: fields are copied from the E inputs.
  - misalign_mw = misalign & (mem_read_e|mem_write_e).
  - en=0: hold all fields.
- rd_data (registered):
  - en=1 & clear=1: 0.
  - en=1 & load completing in DONE: response buffer.
  - en=1 otherwise: 0.
  - en=0: hold value, so the stall holds load data.
- Counters:
  - Saturate at all-ones.
  - cnt_clr takes priority over an increment in the same cycle.
- Once accepted, a transaction always completes. A mid-flight clear only zeroes the MW contents at the advance.
- mem_rvalid outside WAIT is ignored.

Decomposition:
- Package mem_wb_pkg holds: size encodings SZ_B/SZ_H/SZ_W/SZ_D, the FSM state enum, and a BE_W/offset-width helper function.
- One sub-module, mem_lane_align (combinational): takes size, address offset and store data; produces mem_be, mem_wdata and misalign.

Test Plan:
- Word store to 0x104, data 0xDEADBEEF, mem_ready=1, rvalid one cycle later with hit=1 -> mem_be=1111, mem_addr=0x104, mem_stall high for 2 cycles, hit_cnt=1.
- Byte store of 0xAB to 0x203 -> mem_be=1000, mem_wdata=0xABABABAB. Half store to 0x202 -> mem_be=1100.
- Load from 0x40 with mem_ready held low for 3 cycles, then rvalid 4 cycles later with rdata=0x12345678 and hit=0 -> state sequence REQ×3, WAIT, DONE; rd_data=0x12345678 after advance; miss_cnt=1.
- Load completes, then en=0 for 2 cycles -> rd_data stays 0x12345678; with clear=1 and en=1 -> rd_data=0 and all MW fields 0.
- Half load at 0x41 -> no mem_req, mem_stall=0, misalign_mw=1 after advance.
- Preload miss_cnt to all-ones, then another miss -> stays all-ones; cnt_clr coincident with a hit -> hit_cnt=0. Assert rst_n=0 during WAIT -> FSM returns to IDLE immediately and outputs are 0.
